// File: rtl/arithmetic_operation.sv
// Registered ALU stage: one-cycle latency, result plus carry/borrow, zero and signed-overflow flags.
// At WIDTH=1 with ADD selected it acts as a registered half adder.
module arithmetic_operation #(
  parameter int          WIDTH      = 1,
  parameter logic [2:0]  DEFAULT_OP = 3'b000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             overflow_out,
  output logic             valid_out
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;
  localparam logic [2:0] OP_DEC  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  // Most positive / most negative signed values; collapse to 0 / 1 at WIDTH=1.
  localparam logic [WIDTH-1:0] SMAX = ALL_ONES >> 1;
  localparam logic [WIDTH-1:0] SMIN = ~SMAX;
  localparam logic [WIDTH:0]   ONE  = {{WIDTH{1'b0}}, 1'b1};

  // DEFAULT_OP only documents the tie-off value of op_in.
  logic unused_default_op;
  assign unused_default_op = ^DEFAULT_OP;

  logic [WIDTH:0] ext_a, ext_b, wide;
  logic           ovf;
  logic           msb_a, msb_b, msb_r;

  assign ext_a = {1'b0, a_in};
  assign ext_b = {1'b0, b_in};
  assign msb_a = a_in[WIDTH-1];
  assign msb_b = b_in[WIDTH-1];
  assign msb_r = wide[WIDTH-1];

  // Operands are zero-extended, so wide[WIDTH] is carry for adds, borrow for
  // subtracts, and always 0 for logic/pass.
  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    unique case (op_in)
      OP_ADD: begin
        wide = ext_a + ext_b;
        ovf  = (msb_a == msb_b) && (msb_r != msb_a);
      end
      OP_SUB: begin
        wide = ext_a - ext_b;
        ovf  = (msb_a != msb_b) && (msb_r != msb_a);
      end
      OP_AND:  wide = ext_a & ext_b;
      OP_OR:   wide = ext_a | ext_b;
      OP_XOR:  wide = ext_a ^ ext_b;
      OP_INC: begin
        wide = ext_a + ONE;
        ovf  = (a_in == SMAX);
      end
      OP_DEC: begin
        wide = ext_a - ONE;
        ovf  = (a_in == SMIN);
      end
      OP_PASS: wide = ext_a;
      default: begin
        wide = '0;
        ovf  = 1'b0;
      end
    endcase
  end

  // Result flags only update on valid; valid_out tracks valid_in every cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_out      <= '0;
      carry_out    <= 1'b0;
      zero_out     <= 1'b1;
      overflow_out <= 1'b0;
      valid_out    <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        sum_out      <= wide[WIDTH-1:0];
        carry_out    <= wide[WIDTH];
        zero_out     <= (wide[WIDTH-1:0] == '0);
        overflow_out <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_arithmetic_operation.sv
// Directed bench for arithmetic_operation: a WIDTH=1 and a WIDTH=8 instance share op/valid/reset.
module tb_arithmetic_operation;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, valid;
  logic [2:0] op;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic       s1, c1, z1, o1, v1;
  logic [7:0] s8;
  logic       c8, z8, o8, v8;

  int vectors = 0;
  int miscompares = 0;

  arithmetic_operation #(.WIDTH(1), .DEFAULT_OP(3'b000)) u1 (
    .clk(clk), .rst_n(rst_n), .a_in(a1), .b_in(b1), .op_in(op), .valid_in(valid),
    .sum_out(s1), .carry_out(c1), .zero_out(z1), .overflow_out(o1), .valid_out(v1)
  );

  arithmetic_operation #(.WIDTH(8), .DEFAULT_OP(3'b000)) u8 (
    .clk(clk), .rst_n(rst_n), .a_in(a8), .b_in(b8), .op_in(op), .valid_in(valid),
    .sum_out(s8), .carry_out(c8), .zero_out(z8), .overflow_out(o8), .valid_out(v8)
  );

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, INC = 3'd5, DEC = 3'd6, PASS = 3'd7;

  // Drive on the falling edge, then observe 1 ns after the next rising edge.
  task automatic step(input logic r, input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic v);
    @(negedge clk);
    rst_n = r; op = o; a8 = a; b8 = b; a1 = a[0]; b1 = b[0]; valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, ADD, 8'hFF, 8'h01, 1'b1);
    vectors++;
    if ({s8, c8, z8, o8, v8} !== {8'h00, 4'b0100}) begin
      miscompares++;
      $display("FAIL reset_w8: got %h expected %h", {s8, c8, z8, o8, v8}, {8'h00, 4'b0100});
    end
    vectors++;
    if ({s1, c1, z1, o1, v1} !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_w1: got %b expected %b", {s1, c1, z1, o1, v1}, 5'b00100);
    end
  endtask

  task automatic test_half_adder();
    // {sum, carry, zero, overflow, valid} for ab = 00, 01, 10, 11
    logic [4:0] exp [4] = '{5'b00101, 5'b10001, 5'b10001, 5'b01111};
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      step(1'b1, ADD, {7'd0, ab[1]}, {7'd0, ab[0]}, 1'b1);
      vectors++;
      if ({s1, c1, z1, o1, v1} !== exp[i]) begin
        miscompares++;
        $display("FAIL half_adder_%0d: got %b expected %b", i, {s1, c1, z1, o1, v1}, exp[i]);
      end
    end
  endtask

  task automatic test_toggle();
    logic ta, tb;
    for (int i = 0; i < 8; i++) begin
      tb = i[0];
      ta = i[1];
      step(1'b1, ADD, {7'd0, ta}, {7'd0, tb}, 1'b1);
      vectors++;
      if ({s1, c1, v1} !== {ta ^ tb, ta & tb, 1'b1}) begin
        miscompares++;
        $display("FAIL toggle_%0d: got %b expected %b", i, {s1, c1, v1}, {ta ^ tb, ta & tb, 1'b1});
      end
      // Mid-cycle glitch on the operands must not reach the registered outputs.
      a1 = ~a1; b1 = ~b1;
      #2;
      vectors++;
      if ({s1, c1} !== {ta ^ tb, ta & tb}) begin
        miscompares++;
        $display("FAIL toggle_glitch_%0d: got %b expected %b", i, {s1, c1}, {ta ^ tb, ta & tb});
      end
    end
  endtask

  // Back-to-back WIDTH=8 operations; expected {sum, carry, zero, overflow, valid}.
  task automatic test_w8_ops();
    logic [2:0]  vop [13] = '{ADD, ADD, SUB, DEC, INC, AND_, OR_, XOR_, PASS, SUB, DEC, INC, SUB};
    logic [7:0]  va  [13] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5,
                              8'h80, 8'h00, 8'h7F, 8'h07};
    logic [7:0]  vb  [13] = '{8'h01, 8'h01, 8'h07, 8'h00, 8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h0F,
                              8'h01, 8'h00, 8'h00, 8'h07};
    logic [11:0] exp [13] = '{{8'h00, 4'b1101}, {8'h80, 4'b0011}, {8'hFE, 4'b1001},
                              {8'h7F, 4'b0011}, {8'h00, 4'b1101}, {8'h05, 4'b0001},
                              {8'hAF, 4'b0001}, {8'hAA, 4'b0001}, {8'hA5, 4'b0001},
                              {8'h7F, 4'b0011}, {8'hFF, 4'b1001}, {8'h80, 4'b0011},
                              {8'h00, 4'b0101}};
    for (int i = 0; i < 13; i++) begin
      step(1'b1, vop[i], va[i], vb[i], 1'b1);
      vectors++;
      if ({s8, c8, z8, o8, v8} !== exp[i]) begin
        miscompares++;
        $display("FAIL w8_op_%0d(op=%0d a=%h b=%h): got %h expected %h",
                 i, vop[i], va[i], vb[i], {s8, c8, z8, o8, v8}, exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b1, ADD, 8'h12, 8'h34, 1'b1);
    vectors++;
    if ({s8, c8, z8, o8, v8} !== {8'h46, 4'b0001}) begin
      miscompares++;
      $display("FAIL hold_load: got %h expected %h", {s8, c8, z8, o8, v8}, {8'h46, 4'b0001});
    end
    step(1'b1, XOR_, 8'hFF, 8'h0F, 1'b0);
    vectors++;
    if ({s8, c8, z8, o8, v8} !== {8'h46, 4'b0000}) begin
      miscompares++;
      $display("FAIL hold_idle: got %h expected %h", {s8, c8, z8, o8, v8}, {8'h46, 4'b0000});
    end
    step(1'b1, 3'bxxx, 8'hxx, 8'hxx, 1'b0);
    vectors++;
    if ({s8, c8, z8, o8, v8} !== {8'h46, 4'b0000}) begin
      miscompares++;
      $display("FAIL hold_x_w8: got %h expected %h", {s8, c8, z8, o8, v8}, {8'h46, 4'b0000});
    end
    vectors++;
    if ({s1, c1, z1, o1, v1} !== 5'b00100) begin
      miscompares++;
      $display("FAIL hold_x_w1: got %b expected %b", {s1, c1, z1, o1, v1}, 5'b00100);
    end
  endtask

  task automatic test_reset_midstream();
    step(1'b1, ADD, 8'h01, 8'h01, 1'b1);
    vectors++;
    if ({s8, c8, z8, o8, v8} !== {8'h02, 4'b0001}) begin
      miscompares++;
      $display("FAIL mid_pre: got %h expected %h", {s8, c8, z8, o8, v8}, {8'h02, 4'b0001});
    end
    step(1'b0, ADD, 8'h10, 8'h10, 1'b1);
    vectors++;
    if ({s8, c8, z8, o8, v8} !== {8'h00, 4'b0100}) begin
      miscompares++;
      $display("FAIL mid_reset: got %h expected %h", {s8, c8, z8, o8, v8}, {8'h00, 4'b0100});
    end
    step(1'b1, ADD, 8'h03, 8'h04, 1'b1);
    vectors++;
    if ({s8, c8, z8, o8, v8} !== {8'h07, 4'b0001}) begin
      miscompares++;
      $display("FAIL mid_resume: got %h expected %h", {s8, c8, z8, o8, v8}, {8'h07, 4'b0001});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; op = ADD; a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_half_adder();
    test_toggle();
    test_w8_ops();
    test_hold();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arithmetic_operation.md
Name: arithmetic_operation

Overview:
- Registered arithmetic/logic unit for two WIDTH-bit operands.
- With WIDTH=1 and op ADD it behaves as a registered half adder: sum = a XOR b, carry = a AND b.
- Sits in the datapath as a one-cycle-latency compute stage. It produces sum/result, carry/borrow, zero and signed-overflow flags with a valid strobe.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).
- DEFAULT_OP, 3'b000, operation used when op_in is tied to its default (ADD). Documentation only; there is no internal override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- a_in  input  WIDTH  operand A, unsigned or two's complement.
- b_in  input  WIDTH  operand B.
- op_in  input  3  operation select.
- valid_in  input  1  operands/op valid this cycle.
- sum_out  output  WIDTH  registered result.
- carry_out  output  1  registered carry (ADD/INC) or borrow (SUB/DEC); 0 for logic/pass ops.
- zero_out  output  1  registered: sum_out == 0.
- overflow_out  output  1  registered signed overflow.
- valid_out  output  1  registered copy of valid_in.

Behaviour:
- One clock, one reset domain. Reset is synchronous and active-low: on a rising clk with rst_n=0, the outputs are forced to sum_out=0, carry_out=0, zero_out=1, overflow_out=0 and valid_out=0.
- Reset has priority over valid_in. Asserting reset mid-stream discards the in-flight result, and the next cycle shows reset values.
- Latency is exactly 1 cycle. Operands, op and valid_in sampled at edge N appear on the outputs after edge N. There is no backpressure; a new operation can be accepted every cycle.
- valid_out <= valid_in every non-reset cycle.
- When valid_in=0, sum_out, carry_out, zero_out and overflow_out hold their previous values. Only valid_out drops.
- Operation encoding (computed at WIDTH+1 bits; sum_out is the low WIDTH bits):
  - 000 ADD: a+b, carry = bit WIDTH.
  - 001 SUB: a-b, carry = borrow = (a < b unsigned).
  - 010 AND: a&b, carry 0.
  - 011 OR: a|b, carry 0.
  - 100 XOR: a^b, carry 0.
  - 101 INC: a+1, carry = (a == all-ones).
  - 110 DEC: a-1, carry = borrow = (a == 0).
  - 111 PASS: a, carry 0.
- overflow_out (signed):
  - ADD: a[MSB]==b[MSB] && sum[MSB]!=a[MSB].
  - SUB: a[MSB]!=b[MSB] && sum[MSB]!=a[MSB].
  - INC: a == 0111..1 (for WIDTH=1: a==0).
  - DEC: a == 1000..0 (for WIDTH=1: a==1).
  - Logic/PASS: 0.
- zero_out is derived from the newly registered result, not from the previous value.
- Wrap-around: ADD/INC wrap modulo 2^WIDTH and SUB/DEC wrap modulo 2^WIDTH. Flags report the wrap and no saturation is applied.
- Inputs are sampled only at the clock edge. Combinational toggling between edges has no effect.
- No X propagation is allowed on outputs after reset. Inputs that are X when valid_in=0 must not corrupt the held outputs.

Test Plan:
- WIDTH=1, ADD, valid_in=1, apply (a,b) = 00, 01, 10, 11 on consecutive cycles.
  - Outputs one cycle later: (sum,carry) = (0,0), (1,0), (1,0), (0,1).
  - zero_out = 1, 0, 0, 1.
  - overflow_out = 0, 0, 0, 1.
- WIDTH=1, ADD, toggle b every 10 ns and a every 20 ns (clk period 10 ns, valid_in=1).
  - Every cycle, sum_out = XOR and carry_out = AND of the values sampled on the previous edge.
- WIDTH=8:
  - ADD 0xFF+0x01 -> sum 0x00, carry 1, zero 1, overflow 0.
  - ADD 0x7F+0x01 -> sum 0x80, carry 0, overflow 1.
- WIDTH=8:
  - SUB 0x05-0x07 -> sum 0xFE, carry (borrow) 1, overflow 0.
  - DEC 0x80 -> sum 0x7F, overflow 1.
  - INC 0xFF -> sum 0x00, carry 1.
- WIDTH=8, logic ops on a=0xA5, b=0x0F:
  - AND -> 0x05, OR -> 0xAF, XOR -> 0xAA, PASS -> 0xA5.
  - carry 0 and overflow 0 in all four cases.
- Hold and reset:
  - After a result, drive valid_in=0 with changing operands: outputs hold and valid_out=0.
  - Assert rst_n=0 for one edge while valid_in=1: next cycle shows sum 0, carry 0, zero 1, overflow 0, valid_out 0.
  - Deassert rst_n: normal operation resumes on the following edge.
